serial_add_sub: RTL
===================

Name: serial_add_sub

Overview:
- Bit-serial adder/subtractor built around a single full-adder slice and a carry flip-flop.
- Adds or subtracts two WIDTH-bit operands LSB-first, one bit per clock, using a start/busy/done handshake.
- Area-cheap counterpart to the combinational full adder; sits next to it in the arithmetic library.
- Used wherever latency of WIDTH+1 cycles is acceptable in exchange for one adder slice.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a−b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse: result valid.
- result  output  WIDTH  sum/difference, registered.
- cout  output  1  carry out of MSB (for sub: 1 = no borrow).
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (sampled on a clk edge, wins over everything):
  - state→IDLE; busy, done, result, cout and overflow all 0.
  - Internal shift registers, carry and bit counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - Latch opA=a and opB = sub ? ~b : b.
  - carry=sub, count=0; state→RUN; busy=1 after E0.
- IDLE, start=0: remain IDLE.
- RUN, at each edge E1..E_WIDTH:
  - Bit i = opA[0], opB[0].
  - s = opA[0]^opB[0]^carry; carry ← opA[0]&opB[0] | carry&(opA[0]^opB[0]).
  - Shift opA and opB right by one; shift s into the MSB of the internal sum register; count++.
  - Before the MSB step (count = WIDTH−1), latch carry as c_msb_in.
- At edge E_WIDTH (MSB processed):
  - state→DONE; result ← internal sum with MSB s; cout ← new carry; overflow ← c_msb_in ^ new carry.
  - done=1 and busy=0 after E_WIDTH.
- DONE: lasts exactly one cycle; at E_WIDTH+1 state→IDLE and done=0.
- Latency: done is high in the cycle beginning at edge E_WIDTH, i.e. WIDTH edges after the start edge.
- Throughput: one operation per WIDTH+1 cycles minimum; next start accepted at E_WIDTH+1 earliest.
- start during RUN or DONE: ignored. Changes on a/b/sub after E0 have no effect.
- result, cout and overflow hold their last values from DONE until the next DONE or reset. They do not change during RUN.
- Arithmetic is modulo 2^WIDTH. Subtraction is a + ~b + 1.
- Reset mid-RUN: abort, no done pulse, outputs cleared to 0; a subsequent start behaves as from power-on.

Test Plan (WIDTH=8):
- Add, start at E0 with a=0x35, b=0x4A, sub=0 -> busy high E1..E7, done only after E8; result=0x7F, cout=0, overflow=0.
- Carry/overflow on add: 0xFF+0x01 -> result=0x00, cout=1, overflow=0. 0x7F+0x01 -> result=0x80, cout=0, overflow=1.
- Subtract: 0x05−0x07 -> result=0xFE, cout=0, overflow=0. 0x80−0x01 -> result=0x7F, cout=1, overflow=1.
- Start ignored while active:
  - Start 0x10+0x20, then hold start=1 with a=0xAA, b=0x55 through RUN and DONE.
  - Expect: result=0x30 with exactly one done pulse; the second operation begins at E9 and yields 0xFF after E17.
  - result holds 0x30 until then.
- Reset mid-operation:
  - Start 0x12+0x34, assert rst at E4 -> busy=0, result=0, no done.
  - Then start 0x01+0x02 -> result=0x03, done after 8 edges.
- Randomised sweep: 1000 random (a, b, sub) -> result, cout and overflow match a reference model; done pulses exactly once per accepted start.

Source files
------------

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor using one full-adder slice, LSB first
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] opa_q, opb_q, sum_q, result_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, busy_q, done_q, cout_q, ovf_q;
    logic             s_d, carry_d;
    logic [WIDTH-1:0] sum_d;
    // single full-adder slice on the current LSBs
    always_comb begin
        s_d     = opa_q[0] ^ opb_q[0] ^ carry_q;
        carry_d = (opa_q[0] & opb_q[0]) | (carry_q & (opa_q[0] ^ opb_q[0]));
        sum_d   = {s_d, sum_q[WIDTH-1:1]};
    end
    // control FSM and datapath; carry_q on the MSB step is the carry into the MSB
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    opa_q   <= opa_q >> 1;
                    opb_q   <= opb_q >> 1;
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= sum_d;
                        cout_q   <= carry_d;
                        ovf_q    <= carry_q ^ carry_d;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        opa_q   <= a;
                        opb_q   <= sub ? ~b : b;
                        carry_q <= sub;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule
